vend_payment_ctrl: RTL
======================

Name: vend_payment_ctrl

Overview:
- Payment sequencer for the reseller. It accumulates inserted coin credit, checks that credit against a selected item price, fires a vend, and returns change.
- All arithmetic is time-shared on one WIDTH-bit addern instance (a+b → {carry,sum}, no carry-in).
- Subtraction is done in two adder passes: credit + ~price, then +1.
- Sits between the coin/selection front end and the dispense/change actuators.

Parameters:
- WIDTH, 8, credit/price/coin width in money units.
- TIMEOUT_CYCLES, 1000, idle cycles before auto-refund. Used only with RESELLER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- coin_valid  in  1  one-cycle coin-insert strobe
- coin_val  in  WIDTH  value of the inserted coin
- coin_ack  out  1  one-cycle pulse: coin added to credit
- coin_rej  out  1  one-cycle pulse: coin refused (credit would overflow)
- sel_valid  in  1  one-cycle item-select strobe
- sel_price  in  WIDTH  price of the selected item
- cancel  in  1  one-cycle refund request
- vend  out  1  one-cycle dispense pulse
- short  out  1  one-cycle pulse: insufficient credit
- chg_valid  out  1  change offer valid
- chg_amt  out  WIDTH  change amount, stable while chg_valid=1
- chg_ready  in  1  change actuator accepts
- credit  out  WIDTH  current credit register
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; credit=0; operand registers=0.
  - coin_ack, coin_rej, vend, short, chg_valid, busy all 0; chg_amt=0.
  - Reset mid-transaction discards credit.
- States: IDLE, ADD, SUB1, SUB2, VEND, CHANGE.
- Input sampling:
  - Inputs are sampled only in IDLE (busy=0). Strobes arriving while busy are ignored.
  - Same-edge priority: cancel > sel_valid > coin_valid.
- IDLE, coin_valid at edge k:
  - Latch coin_val and go to ADD.
  - At edge k+1 the adder computes credit+op.
  - carry=1: credit unchanged; coin_rej=1 for the cycle after edge k+1.
  - carry=0: credit<=sum; coin_ack=1 for that same cycle.
  - Return to IDLE.
- IDLE, sel_valid at edge k:
  - Latch sel_price and go to SUB1.
  - Edge k+1: T<=credit+~price, c1<=carry. Go to SUB2.
  - Edge k+2: D<=T+1, c2<=carry.
  - Sufficient credit iff c1|c2.
- Sufficient credit:
  - credit<=D; go to VEND. vend=1 for exactly one cycle.
  - From VEND: go to CHANGE if credit!=0, else IDLE.
- Insufficient credit:
  - short=1 for one cycle; credit unchanged; return to IDLE.
- Price 0: always sufficient; credit unchanged.
- IDLE, cancel:
  - credit!=0: go to CHANGE.
  - credit==0: no-op, stays IDLE, no pulse.
- CHANGE:
  - chg_valid=1, chg_amt=credit, held until chg_valid&chg_ready at a rising edge.
  - On that edge: credit<=0, chg_valid drops, return to IDLE.
  - chg_ready outside CHANGE is ignored.
- Width rules:
  - All adder operands are exactly WIDTH bits; ~price is a bitwise WIDTH-bit inversion.
  - credit never exceeds 2^WIDTH-1; overflow is prevented by coin rejection.
- Outputs are registered except busy, which decodes state.

Optional Feature:
- Macro: RESELLER_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in IDLE while credit!=0.
  - It clears on any accepted strobe, on leaving IDLE, and when credit==0.
  - When the count reaches TIMEOUT_CYCLES-1, the FSM goes to CHANGE (auto-refund) on the next edge.
  - The counter resets asynchronously with rst_n.
- Without the macro: no counter logic; credit is held indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package holds:
  - state enum constants: IDLE=0, ADD=1, SUB1=2, SUB2=3, VEND=4, CHANGE=5, 3-bit encoding;
  - default WIDTH and TIMEOUT_CYCLES constants.
- One sub-module: a single addern #(WIDTH) instance. Its a/b inputs are muxed by state:
  - ADD: credit, coin;
  - SUB1: credit, ~price;
  - SUB2: T, 1.
- No other arithmetic instance is permitted.

Test Plan:
1. Coin insert: reset; coin 5 then coin 10 (in IDLE) → coin_ack pulses twice, each one cycle after edge k+1; credit=15.
2. Vend with change: credit 15, sel_price 12 → vend one cycle after edge k+2, credit=3; then chg_valid=1, chg_amt=3. Hold chg_ready=0 for 3 cycles → chg_amt stays 3. chg_ready=1 → credit=0, IDLE.
3. Exact price and short: credit 10, price 10 → vend, credit 0, no chg_valid. Then credit 9, price 10 → short pulse, credit=9, no vend.
4. Overflow and priority:
   - credit 250, coin 10 → coin_rej, credit=250.
   - cancel+coin_valid on the same edge → CHANGE with chg_amt=250, coin ignored.
   - coin_valid while busy → no ack or rej.
5. Reset: assert rst_n=0 asynchronously mid-CHANGE and mid-SUB1 → all outputs 0 immediately; credit=0; busy=0.
6. Timeout: with RESELLER_TIMEOUT_EN and TIMEOUT_CYCLES=8, credit 5 idle → chg_valid asserts after 8 idle cycles. Without the macro, 100 idle cycles → no chg_valid.

Source files
------------

// File: rtl/vend_payment_ctrl_pkg.sv
// Shared types and default sizing for the vend payment controller.
package vend_payment_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADD    = 3'd1,
        SUB1   = 3'd2,
        SUB2   = 3'd3,
        VEND   = 3'd4,
        CHANGE = 3'd5
    } VendState;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/vend_payment_ctrl_if.sv
// Front-end / actuator signal bundle for the vend payment controller.
interface vend_payment_ctrl_if
    import vend_payment_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             coin_valid;
    logic [WIDTH-1:0] coin_val;
    logic             coin_ack;
    logic             coin_rej;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_price;
    logic             cancel;
    logic             vend;
    logic             short;
    logic             chg_valid;
    logic [WIDTH-1:0] chg_amt;
    logic             chg_ready;
    logic [WIDTH-1:0] credit;
    logic             busy;

    modport master (
        output coin_valid, coin_val, sel_valid, sel_price, cancel, chg_ready,
        input  coin_ack, coin_rej, vend, short, chg_valid, chg_amt, credit, busy
    );

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_price, cancel, chg_ready,
        output coin_ack, coin_rej, vend, short, chg_valid, chg_amt, credit, busy
    );

endinterface

// File: rtl/vend_payment_ctrl_addern.sv
// WIDTH-bit adder without carry-in; the only arithmetic unit of the controller.
module addern #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/vend_payment_ctrl.sv
// Payment sequencer: coin credit, price check, vend and change on one shared adder.
// Optional idle auto-refund is enabled by defining RESELLER_TIMEOUT_EN.
module vend_payment_ctrl
    import vend_payment_ctrl_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                clk,
    input logic                rst_n,
    vend_payment_ctrl_if.slave bus
);

    VendState         r_state, w_nextState;
    logic [WIDTH-1:0] r_credit, w_nextCredit;
    logic [WIDTH-1:0] r_op, w_nextOp;
    logic [WIDTH-1:0] r_t, w_nextT;
    logic             r_c1, w_nextC1;
    logic             r_coinAck, w_nextCoinAck;
    logic             r_coinRej, w_nextCoinRej;
    logic             r_vend, w_nextVend;
    logic             r_short, w_nextShort;
    logic             r_chgValid, w_nextChgValid;
    logic [WIDTH-1:0] r_chgAmt, w_nextChgAmt;
    logic [WIDTH-1:0] w_adderA, w_adderB, w_sum;
    logic             w_carry;
    logic             w_timeoutHit;

    // Subtraction is credit + ~price followed by +1; either pass carrying means credit >= price.
    always_comb begin
        w_adderA = '0;
        w_adderB = '0;
        case (r_state)
            ADD: begin
                w_adderA = r_credit;
                w_adderB = r_op;
            end
            SUB1: begin
                w_adderA = r_credit;
                w_adderB = ~r_op;
            end
            SUB2: begin
                w_adderA = r_t;
                w_adderB = WIDTH'(1);
            end
            default: ;
        endcase
    end

    addern #(.WIDTH(WIDTH)) u_adder (
        .i_a     (w_adderA),
        .i_b     (w_adderB),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_comb begin
        w_nextState    = r_state;
        w_nextCredit   = r_credit;
        w_nextOp       = r_op;
        w_nextT        = r_t;
        w_nextC1       = r_c1;
        w_nextCoinAck  = 1'b0;
        w_nextCoinRej  = 1'b0;
        w_nextVend     = 1'b0;
        w_nextShort    = 1'b0;
        w_nextChgValid = r_chgValid;
        w_nextChgAmt   = r_chgAmt;
        case (r_state)
            IDLE: begin
                if (bus.cancel) begin
                    if (r_credit != '0) begin
                        w_nextState    = CHANGE;
                        w_nextChgValid = 1'b1;
                        w_nextChgAmt   = r_credit;
                    end
                end else if (bus.sel_valid) begin
                    w_nextOp    = bus.sel_price;
                    w_nextState = SUB1;
                end else if (bus.coin_valid) begin
                    w_nextOp    = bus.coin_val;
                    w_nextState = ADD;
                end else if (w_timeoutHit) begin
                    w_nextState    = CHANGE;
                    w_nextChgValid = 1'b1;
                    w_nextChgAmt   = r_credit;
                end
            end
            ADD: begin
                if (w_carry) begin
                    w_nextCoinRej = 1'b1;
                end else begin
                    w_nextCredit  = w_sum;
                    w_nextCoinAck = 1'b1;
                end
                w_nextState = IDLE;
            end
            SUB1: begin
                w_nextT     = w_sum;
                w_nextC1    = w_carry;
                w_nextState = SUB2;
            end
            SUB2: begin
                if (r_c1 | w_carry) begin
                    w_nextCredit = w_sum;
                    w_nextVend   = 1'b1;
                    w_nextState  = VEND;
                end else begin
                    w_nextShort = 1'b1;
                    w_nextState = IDLE;
                end
            end
            VEND: begin
                if (r_credit != '0) begin
                    w_nextState    = CHANGE;
                    w_nextChgValid = 1'b1;
                    w_nextChgAmt   = r_credit;
                end else begin
                    w_nextState = IDLE;
                end
            end
            CHANGE: begin
                if (bus.chg_ready) begin
                    w_nextCredit   = '0;
                    w_nextChgValid = 1'b0;
                    w_nextChgAmt   = '0;
                    w_nextState    = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_credit   <= '0;
            r_op       <= '0;
            r_t        <= '0;
            r_c1       <= 1'b0;
            r_coinAck  <= 1'b0;
            r_coinRej  <= 1'b0;
            r_vend     <= 1'b0;
            r_short    <= 1'b0;
            r_chgValid <= 1'b0;
            r_chgAmt   <= '0;
        end else begin
            r_state    <= w_nextState;
            r_credit   <= w_nextCredit;
            r_op       <= w_nextOp;
            r_t        <= w_nextT;
            r_c1       <= w_nextC1;
            r_coinAck  <= w_nextCoinAck;
            r_coinRej  <= w_nextCoinRej;
            r_vend     <= w_nextVend;
            r_short    <= w_nextShort;
            r_chgValid <= w_nextChgValid;
            r_chgAmt   <= w_nextChgAmt;
        end
    end

`ifdef RESELLER_TIMEOUT_EN
    logic [31:0] r_idleCnt;

    assign w_timeoutHit = (r_credit != '0) && (r_idleCnt == 32'(TIMEOUT_CYCLES - 1));

    // Counts only while credit sits untouched in IDLE; any strobe or exit restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idleCnt <= '0;
        end else if (r_state == IDLE && w_nextState == IDLE && r_credit != '0) begin
            r_idleCnt <= r_idleCnt + 32'd1;
        end else begin
            r_idleCnt <= '0;
        end
    end
`else
    logic w_unusedTimeout;

    assign w_timeoutHit    = 1'b0;
    assign w_unusedTimeout = ^TIMEOUT_CYCLES;
`endif

    assign bus.coin_ack  = r_coinAck;
    assign bus.coin_rej  = r_coinRej;
    assign bus.vend      = r_vend;
    assign bus.short     = r_short;
    assign bus.chg_valid = r_chgValid;
    assign bus.chg_amt   = r_chgAmt;
    assign bus.credit    = r_credit;
    assign bus.busy      = (r_state != IDLE);

endmodule
